pc_stack16: RTL and testbench
=============================

# pc_stack16

Sixteen-bit program counter with an integrated return-address stack, sitting directly downstream of `Increment16`. It consumes the incremented value for sequential fetch and for return-address pushes. It registers the current instruction address for the fetch path and supports the following operations:
- absolute load;
- call (jump plus push of the return address);
- return (pop into the PC);
- increment;
- hold.

## Interface
Parameters:
- `WIDTH`, 16, address width; fixed at 16 for this design.
- `DEPTH`, 4, number of return-stack entries; must be a power of two, 2..16.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in`  input  16  load/call target address.
- `load`  input  1  load `in` into PC.
- `call`  input  1  jump to `in`, push PC+1.
- `ret`  input  1  pop top of stack into PC.
- `inc`  input  1  PC <= PC+1.
- `out`  output  16  current PC (registered).
- `sp`  output  $clog2(DEPTH)+1  number of valid stack entries.
- `full`  output  1  `sp == DEPTH`.
- `empty`  output  1  `sp == 0`.
- `overflow`  output  1  sticky; call attempted while full.
- `underflow`  output  1  sticky; ret attempted while empty.

## Operation
Per-cycle priority, highest first: reset > load > call > ret > inc > hold. Exactly one action is taken per cycle; lower-priority requests in the same cycle are ignored.

- **reset**: `out`=0x0000, `sp`=0, `overflow`=0, `underflow`=0. Stack contents are don't-care.
- **load**: `out` <= `in`. Stack is untouched.
- **call, not full**:
  - `stack[sp]` <= `out`+1, where `out`+1 comes from `Increment16`, so 0xFFFF pushes 0x0000.
  - `sp` <= `sp`+1.
  - `out` <= `in`.
- **call, full**:
  - `out` <= `in`; the jump still happens.
  - Push is discarded; `sp` is unchanged and no entry is overwritten.
  - `overflow` <= 1.
- **ret, not empty**: `out` <= `stack[sp-1]`, `sp` <= `sp`-1.
- **ret, empty**: `out` holds, `sp` holds, `underflow` <= 1.
- **inc**: `out` <= `out`+1, taken from `Increment16`. Wraps 0xFFFF -> 0x0000 with no flag.
- **hold**: no request asserted; all state is unchanged.

Stack behaviour:
- The stack is LIFO.
- Entries at index >= `sp` are invalid and are never read.

Flags:
- `overflow` and `underflow` are sticky; only `reset` clears them.
- Setting a flag has no other side effect.

## Timing
- All state is registered on the rising edge of `clk`. The new `out` is visible one cycle after the request is sampled.
- Decoding of `full`, `empty` and `sp` is a pure function of the stack-pointer register, so it changes in the same cycle as `out`.
- There is no combinational path from any input to any output.
- Back-to-back requests are accepted every cycle:
  - call then ret on consecutive cycles returns to the called-from address +1 after 2 cycles;
  - ret in the cycle after a full-stack call pops the last pushed entry, not the discarded one.
- Reset asserted mid-sequence (e.g. `sp`=3) takes effect at the next edge regardless of other inputs.
- After reset the stack is empty; a subsequent ret sets `underflow`.

## Structure
- Shared header `pc_defs.vh` holds:
  - `PC_WIDTH` (16);
  - `PC_STACK_DEPTH` default (4);
  - `PC_RESET_VECTOR` (16'h0000).
- Reuse the existing `Increment16` as the single sub-module.
  - One instance feeds both the inc path and the call push data.
  - No second adder.
- Stack is a register array of `DEPTH` x 16 with one write port and one read port at `sp-1`.
- Next-state mux and `sp` logic live in the top module.
- Expected size: about 150 lines of RTL.

## Test plan
- **Reset then inc**: reset 1 cycle, then `inc`=1 for 3 cycles -> `out` 0x0000, 0x0001, 0x0002, 0x0003; `empty`=1, `sp`=0.
- **Load and wrap**: `load` `in`=0xFFFE, then inc x2 -> `out` 0xFFFE, 0xFFFF, 0x0000; no flag set.
- **Call/return**:
  - `load` 0x0010;
  - `call` `in`=0x0200 -> `out`=0x0200, `sp`=1;
  - inc -> 0x0201;
  - `ret` -> `out`=0x0011, `sp`=0.
- **Overflow**:
  - 4 calls (targets 0x0100..0x0400) from `out`=0x0000 -> `sp`=4, `full`=1;
  - 5th call `in`=0x0500 -> `out`=0x0500, `sp`=4, `overflow`=1;
  - ret -> `out`=0x0301.
- **Underflow and priority**:
  - `ret` with `sp`=0 -> `out` unchanged, `underflow`=1;
  - `load`+`call`+`inc` together with `in`=0x1234 -> `out`=0x1234, `sp` unchanged;
  - `reset` -> both flags 0.

Source files
------------

// File: rtl/pc_stack16_pkg.sv
// Shared constants and request decode for the program counter with return stack.
package pc_stack16_pkg;

    localparam int          PC_WIDTH        = 16;
    localparam int          PC_STACK_DEPTH  = 4;
    localparam logic [15:0] PC_RESET_VECTOR = 16'h0000;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_LOAD,
        OP_CALL,
        OP_RET,
        OP_INC
    } pc_op_t;

    // Only the highest-priority request is honoured in a cycle.
    function automatic pc_op_t decode_op(input logic load, input logic call,
                                         input logic ret, input logic inc);
        if (load)      return OP_LOAD;
        else if (call) return OP_CALL;
        else if (ret)  return OP_RET;
        else if (inc)  return OP_INC;
        else           return OP_HOLD;
    endfunction

endpackage

// File: rtl/pc_stack16_inc16.sv
// Sixteen-bit incrementer; wraps 0xFFFF to 0x0000 without a carry out.
module Increment16 (
    input  logic [15:0] a,
    output logic [15:0] y
);

    assign y = a + 16'd1;

endmodule

// File: rtl/pc_stack16.sv
// Program counter with a LIFO return-address stack; one incrementer serves both
// sequential fetch and the call push data.
module pc_stack16
    import pc_stack16_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = PC_STACK_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in,
    input  logic                   load,
    input  logic                   call,
    input  logic                   ret,
    input  logic                   inc,
    output logic [WIDTH-1:0]       out,
    output logic [$clog2(DEPTH):0] sp,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] out_nxt;
    logic [SPW-1:0]   sp_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;
    logic             push_en;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    pc_op_t           op;

    Increment16 u_inc (
        .a (out),
        .y (pc_plus1)
    );

    assign full   = (sp == SP_FULL);
    assign empty  = (sp == '0);
    assign wr_idx = sp[AW-1:0];
    assign rd_idx = AW'(sp - 1'b1);

    always_comb begin
        op      = decode_op(load, call, ret, inc);
        out_nxt = out;
        sp_nxt  = sp;
        ovf_nxt = overflow;
        unf_nxt = underflow;
        push_en = 1'b0;
        case (op)
            OP_LOAD: out_nxt = in;
            OP_CALL: begin
                out_nxt = in;
                if (full) begin
                    ovf_nxt = 1'b1;
                end else begin
                    push_en = 1'b1;
                    sp_nxt  = sp + 1'b1;
                end
            end
            OP_RET: begin
                if (empty) begin
                    unf_nxt = 1'b1;
                end else begin
                    out_nxt = stack[rd_idx];
                    sp_nxt  = sp - 1'b1;
                end
            end
            OP_INC:  out_nxt = pc_plus1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= PC_RESET_VECTOR;
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out       <= out_nxt;
            sp        <= sp_nxt;
            overflow  <= ovf_nxt;
            underflow <= unf_nxt;
        end
    end

    // Contents are don't-care after reset; sp alone defines validity.
    always_ff @(posedge clk) begin
        if (!reset && push_en)
            stack[wr_idx] <= pc_plus1;
    end

endmodule

// File: tb/tb_pc_stack16.sv
// Randomised and directed bench for pc_stack16 with a queue-based reference model.
module tb_pc_stack16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        load, call, ret, inc;
    logic [15:0] out;
    logic [2:0]  sp;
    logic        full, empty, overflow, underflow;

    pc_stack16 dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .load      (load),
        .call      (call),
        .ret       (ret),
        .inc       (inc),
        .out       (out),
        .sp        (sp),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] out;
        int          sp;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_stack[$];
    logic [15:0] m_pc;
    logic        m_ovf, m_unf;
    int          total = 0;
    int          bad   = 0;
    bit          stim_done = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic r, input logic ld, input logic cl,
                        input logic rt, input logic ic, input logic [15:0] d);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; load = ld; call = cl; ret = rt; inc = ic; in = d;
        if (r) begin
            m_pc = 16'h0000;
            m_stack.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (ld) begin
            m_pc = d;
        end else if (cl) begin
            if (m_stack.size() < 4) m_stack.push_back(m_pc + 16'd1);
            else                    m_ovf = 1;
            m_pc = d;
        end else if (rt) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else                    m_unf = 1;
        end else if (ic) begin
            m_pc = m_pc + 16'd1;
        end
        e.out = m_pc;
        e.sp  = m_stack.size();
        e.ovf = m_ovf;
        e.unf = m_unf;
        exp_q.push_back(e);
    endtask

    // Monitor: a request applied before this edge is reflected at the next falling edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                @(negedge clk);
                check("out",       int'(out),       int'(e.out));
                check("sp",        int'(sp),        e.sp);
                check("full",      int'(full),      int'(e.sp == 4));
                check("empty",     int'(empty),     int'(e.sp == 0));
                check("overflow",  int'(overflow),  int'(e.ovf));
                check("underflow", int'(underflow), int'(e.unf));
            end
        end
    end

    initial begin
        int k;
        reset = 1; load = 0; call = 0; ret = 0; inc = 0; in = '0;
        m_pc = 0; m_ovf = 0; m_unf = 0;

        // reset then inc x3
        step(1, 0, 0, 0, 0, 16'h0);
        repeat (3) step(0, 0, 0, 0, 1, 16'h0);
        // load and wrap
        step(0, 1, 0, 0, 0, 16'hFFFE);
        repeat (2) step(0, 0, 0, 0, 1, 16'h0);
        // call / inc / return
        step(0, 1, 0, 0, 0, 16'h0010);
        step(0, 0, 1, 0, 0, 16'h0200);
        step(0, 0, 0, 0, 1, 16'h0);
        step(0, 0, 0, 1, 0, 16'h0);
        // overflow: 4 calls from 0, a fifth while full, then ret
        step(1, 0, 0, 0, 0, 16'h0);
        for (int i = 1; i <= 5; i++) step(0, 0, 1, 0, 0, 16'(i * 16'h0100));
        step(0, 0, 0, 1, 0, 16'h0);
        // call pushing 0x0000 from 0xFFFF
        step(1, 0, 0, 0, 0, 16'h0);
        step(0, 1, 0, 0, 0, 16'hFFFF);
        step(0, 0, 1, 0, 0, 16'h4000);
        step(0, 0, 0, 1, 0, 16'h0);
        // underflow and priority
        step(0, 0, 0, 1, 0, 16'h0);
        step(0, 1, 1, 0, 1, 16'h1234);
        step(0, 0, 1, 1, 1, 16'h2222);
        step(0, 0, 0, 1, 1, 16'h0);
        step(1, 1, 1, 1, 1, 16'h5555);
        // mid-sequence reset at sp=3
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 16'($urandom));
        step(1, 0, 1, 0, 0, 16'h7777);
        step(0, 0, 0, 1, 0, 16'h0);

        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 99);
            step(k < 2, k >= 2 && k < 10, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 16'($urandom));
        end
        step(0, 0, 0, 0, 0, 16'h0);
        stim_done = 1;
    end

    initial begin
        int guard;
        guard = 0;
        wait (stim_done);
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
